// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: button FSM state encoding and default
// debounce / long-press timing for the 100 MHz and 23 MHz board clocks.
package board_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_HELD         = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

  // 20 ms debounce window and 1 s long-press time
  localparam int unsigned DEBOUNCE_100M = 32'd2_000_000;
  localparam int unsigned LONG_100M     = 32'd100_000_000;
  localparam int unsigned DEBOUNCE_23M  = 32'd460_000;
  localparam int unsigned LONG_23M      = 32'd23_000_000;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, polarity normalisation, debounce
// FSM with a saturating counter, registered rise/fall/long pulses and a
// toggle latch. DEBOUNCE_CYCLES must be at least 2 and below LONG_CYCLES.
module btn_channel
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_100M,
  parameter int unsigned LONG_CYCLES     = LONG_100M,
  parameter logic        ACT_LOW         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic clear_toggle,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_long,
  output logic btn_toggle
);

  localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  btn_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             long_done_r;
  logic             level_r;
  logic             rise_r;
  logic             fall_r;
  logic             long_r;
  logic             toggle_r;
  logic             norm_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             rise_next_s;

  // Pressed = 1 regardless of pin polarity; the raw pin is never used past ff1
  assign norm_s      = sync2_r ^ ACT_LOW;
  // Saturating increment so a stuck counter can never wrap into a false match
  assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
  assign rise_next_s = (state_r == ST_PRESS_WAIT) && norm_s && (cnt_r == DEB_LAST);

  // Synchroniser plus debounce/long-press FSM with registered level and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r     <= ACT_LOW;
      sync2_r     <= ACT_LOW;
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      long_done_r <= 1'b0;
      level_r     <= 1'b0;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      long_r      <= 1'b0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      long_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          level_r <= 1'b0;
          if (norm_s) begin
            state_r <= ST_PRESS_WAIT;
            cnt_r   <= CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!norm_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DEB_LAST) begin
            state_r     <= ST_PRESSED;
            cnt_r       <= CNT_ZERO;
            rise_r      <= 1'b1;
            level_r     <= 1'b1;
            long_done_r <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_PRESSED: begin
          if (!norm_s) begin
            state_r     <= ST_RELEASE_WAIT;
            cnt_r       <= CNT_ONE;
            long_done_r <= 1'b0;
          end else if (cnt_r == LONG_LAST) begin
            state_r     <= ST_HELD;
            long_r      <= 1'b1;
            long_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_HELD: begin
          if (!norm_s) begin
            state_r     <= ST_RELEASE_WAIT;
            cnt_r       <= CNT_ONE;
            long_done_r <= 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          if (norm_s) begin
            // Release was a bounce: resume, restarting the long timer if it had not fired
            state_r <= long_done_r ? ST_HELD : ST_PRESSED;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == DEB_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            fall_r  <= 1'b1;
            level_r <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          level_r <= 1'b0;
        end
      endcase
    end
  end

  // Toggle latch flips with each accepted press; a same-cycle clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_r <= 1'b0;
    end else if (clear_toggle) begin
      toggle_r <= 1'b0;
    end else if (rise_next_s) begin
      toggle_r <= ~toggle_r;
    end else begin
      toggle_r <= toggle_r;
    end
  end

  assign btn_level  = level_r;
  assign btn_rise   = rise_r;
  assign btn_fall   = fall_r;
  assign btn_long   = long_r;
  assign btn_toggle = toggle_r;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button/switch conditioner: one independent btn_channel per
// pin, producing debounced levels, press/release/long pulses and toggles.
module btn_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned    CH              = 4,
  parameter int unsigned    DEBOUNCE_CYCLES = DEBOUNCE_100M,
  parameter int unsigned    LONG_CYCLES     = LONG_100M,
  parameter logic [CH-1:0]  ACT_LOW         = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn_in,
  input  logic [CH-1:0] clear_toggle,
  output logic [CH-1:0] btn_level,
  output logic [CH-1:0] btn_rise,
  output logic [CH-1:0] btn_fall,
  output logic [CH-1:0] btn_long,
  output logic [CH-1:0] btn_toggle
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACT_LOW        (ACT_LOW[i])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .clear_toggle(clear_toggle[i]),
      .btn_level   (btn_level[i]),
      .btn_rise    (btn_rise[i]),
      .btn_fall    (btn_fall[i]),
      .btn_long    (btn_long[i]),
      .btn_toggle  (btn_toggle[i])
    );
  end

endmodule
